// File: rtl/cdb_wb_arbiter.sv
// Common data bus writeback arbiter: per-producer FIFOs drained one entry per cycle onto a registered CDB.
// Define CDB_FIXED_PRIO_EN for fixed lowest-index priority; default build uses round-robin.
module cdb_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      FLUSH,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      cdb_stall,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [1:0]                cdb_src
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W;

  logic [ENT_W-1:0] mem    [NUM_REQ][DEPTH];
  logic [PTR_W-1:0] wr_ptr [NUM_REQ];
  logic [PTR_W-1:0] rd_ptr [NUM_REQ];
  logic [CNT_W-1:0] count  [NUM_REQ];
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic             any_cand;
  logic             grant;
  logic [1:0]       winner;
  logic [ENT_W-1:0] head;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i]      = (count[i] != '0);
      req_ready[i] = (count[i] != CNT_W'(DEPTH));
      push[i]      = req_valid[i] & req_ready[i] & RESET & ~FLUSH;
    end
  end

`ifdef CDB_FIXED_PRIO_EN
  always_comb begin
    winner   = '0;
    any_cand = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_cand && cand[i]) begin
        winner   = 2'(i);
        any_cand = 1'b1;
      end
    end
  end
`else
  logic [1:0] rr_ptr;

  function automatic logic [1:0] wrap_add(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[1:0];
  endfunction

  // Search order starts at rr_ptr; the first nonempty FIFO in that order wins.
  always_comb begin
    winner   = '0;
    any_cand = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_cand && cand[i] && (2'(i) == wrap_add(rr_ptr, k))) begin
          winner   = 2'(i);
          any_cand = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET || FLUSH) rr_ptr <= '0;
    else if (grant)      rr_ptr <= wrap_add(winner, 1);
  end
`endif

  assign grant = any_cand & ~cdb_stall & ~FLUSH;

  always_comb begin
    head = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i] = grant && (winner == 2'(i));
      if (winner == 2'(i)) head = mem[i][rd_ptr[i]];
    end
  end

  // FIFO storage carries no reset; validity lives entirely in count.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {req_tag[i*TAG_W +: TAG_W], req_data[i*DATA_W +: DATA_W]};
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!RESET || FLUSH) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // CDB output stage: stall freezes everything, an idle cycle only drops valid.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (FLUSH) begin
      cdb_valid <= 1'b0;
    end else if (!cdb_stall) begin
      if (grant) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= head[ENT_W-1 -: TAG_W];
        cdb_data  <= head[DATA_W-1:0];
        cdb_src   <= winner;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed bench for cdb_wb_arbiter: reset, latency, arbitration order, backpressure, stall hold, flush.
module tb_cdb_wb_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;

  logic                      CLK = 1'b0;
  logic                      RESET;
  logic                      FLUSH;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_stall;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [1:0]                cdb_src;

  int nvec = 0;
  int nerr = 0;
  logic [5:0] exp_t3 [6];

  cdb_wb_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
    .cdb_stall(cdb_stall), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1);
    req_valid = v;
    req_tag   = {t1, t0};
    req_data  = {32'h1000 + 32'(t1), 32'h1000 + 32'(t0)};
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef CDB_FIXED_PRIO_EN
    exp_t3 = '{6'd1, 6'd2, 6'd3, 6'd9, 6'd10, 6'd11};
`else
    exp_t3 = '{6'd1, 6'd9, 6'd2, 6'd10, 6'd3, 6'd11};
`endif
    // T1 reset with producers asserting valid
    RESET = 1'b0; FLUSH = 1'b0; cdb_stall = 1'b0;
    drive(2'b11, 6'd33, 6'd44);
    tick;
    chk("t1_valid_r1", 64'(cdb_valid), 64'd0);
    tick;
    chk("t1_valid_r2", 64'(cdb_valid), 64'd0);
    chk("t1_tag_r2", 64'(cdb_tag), 64'd0);
    RESET = 1'b1;
    drive(2'b00, 6'd0, 6'd0);
    chk("t1_ready", 64'(req_ready), 64'd3);
    tick;
    chk("t1_valid_idle", 64'(cdb_valid), 64'd0);
    chk("t1_src_idle", 64'(cdb_src), 64'd0);

    // T2 single push latency
    req_valid = 2'b01; req_tag = {6'd0, 6'd5}; req_data = {32'd0, 32'hDEADBEEF};
    tick;
    drive(2'b00, 6'd0, 6'd0);
    chk("t2_valid_k", 64'(cdb_valid), 64'd0);
    tick;
    chk("t2_valid_k1", 64'(cdb_valid), 64'd1);
    chk("t2_tag", 64'(cdb_tag), 64'd5);
    chk("t2_data", 64'(cdb_data), 64'hDEADBEEF);
    chk("t2_src", 64'(cdb_src), 64'd0);
    tick;
    chk("t2_valid_k2", 64'(cdb_valid), 64'd0);
    chk("t2_tag_hold", 64'(cdb_tag), 64'd5);

    // Flush on an empty design puts the round-robin pointer back at port 0
    FLUSH = 1'b1;
    tick;
    FLUSH = 1'b0;
    chk("pre_t3_valid", 64'(cdb_valid), 64'd0);

    // T3 arbitration order with both ports pushing together
    drive(2'b11, 6'd1, 6'd9);
    tick;
    drive(2'b11, 6'd2, 6'd10);
    tick;
    chk("t3_valid0", 64'(cdb_valid), 64'd1);
    chk("t3_tag0", 64'(cdb_tag), 64'(exp_t3[0]));
    drive(2'b11, 6'd3, 6'd11);
    tick;
    drive(2'b00, 6'd0, 6'd0);
    chk("t3_tag1", 64'(cdb_tag), 64'(exp_t3[1]));
    for (int n = 2; n < 6; n++) begin
      tick;
      chk("t3_valid_n", 64'(cdb_valid), 64'd1);
      chk("t3_tag_n", 64'(cdb_tag), 64'(exp_t3[n]));
      chk("t3_data_n", 64'(cdb_data), 64'(32'h1000 + 32'(exp_t3[n])));
      chk("t3_src_n", 64'(cdb_src), (exp_t3[n] >= 6'd9) ? 64'd1 : 64'd0);
    end
    tick;
    chk("t3_drained", 64'(cdb_valid), 64'd0);

    // T4 fill port 0 under stall, then drain
    cdb_stall = 1'b1;
    for (int n = 0; n < 4; n++) begin
      chk("t4_ready_fill", 64'(req_ready[0]), 64'd1);
      drive(2'b01, 6'(20 + n), 6'd0);
      tick;
    end
    chk("t4_ready_full", 64'(req_ready[0]), 64'd0);
    chk("t4_valid_stalled", 64'(cdb_valid), 64'd0);
    drive(2'b01, 6'd24, 6'd0);
    tick;
    chk("t4_ready_still_full", 64'(req_ready[0]), 64'd0);
    drive(2'b00, 6'd0, 6'd0);
    cdb_stall = 1'b0;
    tick;
    chk("t4_tag_pop0", 64'(cdb_tag), 64'd20);
    chk("t4_ready_back", 64'(req_ready[0]), 64'd1);
    for (int n = 1; n < 4; n++) begin
      tick;
      chk("t4_valid_pop", 64'(cdb_valid), 64'd1);
      chk("t4_tag_pop", 64'(cdb_tag), 64'(20 + n));
    end
    tick;
    chk("t4_no_fifth", 64'(cdb_valid), 64'd0);

    // T5 stall holds a live broadcast and freezes arbitration
    drive(2'b10, 6'd0, 6'd7);
    tick;
    drive(2'b11, 6'd30, 6'd31);
    tick;
    drive(2'b00, 6'd0, 6'd0);
    chk("t5_tag7", 64'(cdb_tag), 64'd7);
    chk("t5_src", 64'(cdb_src), 64'd1);
    cdb_stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick;
      chk("t5_valid_hold", 64'(cdb_valid), 64'd1);
      chk("t5_tag_hold", 64'(cdb_tag), 64'd7);
      chk("t5_data_hold", 64'(cdb_data), 64'h1007);
    end
    cdb_stall = 1'b0;
    tick;
    chk("t5_after_p0", 64'(cdb_tag), 64'd30);
    tick;
    chk("t5_after_p1", 64'(cdb_tag), 64'd31);
    tick;
    chk("t5_drained", 64'(cdb_valid), 64'd0);

    // T6 flush with entries buffered and a concurrent push
    cdb_stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive(2'b11, 6'(40 + n), 6'(50 + n));
      tick;
    end
    cdb_stall = 1'b0;
    FLUSH = 1'b1;
    drive(2'b11, 6'd43, 6'd53);
    tick;
    FLUSH = 1'b0;
    drive(2'b00, 6'd0, 6'd0);
    chk("t6_valid", 64'(cdb_valid), 64'd0);
    chk("t6_ready", 64'(req_ready), 64'd3);
    tick;
    chk("t6_empty1", 64'(cdb_valid), 64'd0);
    tick;
    chk("t6_empty2", 64'(cdb_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
